fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_stage_if_id_reg.sv | 79 +++++++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the RV32I fetch front end: data width,
//               the bubble instruction encoding and the fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    WAIT = 2'd1,  // one request outstanding for PCF
    DROP = 2'd2   // one request outstanding, its response is stale
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with flush and stall.
//               Priority: reset > flush > stall > load > bubble.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               flush_i         - load a bubble (PC fields keep old values)
//               stall_i         - hold contents
//               load_i          - capture instr_i / pc_i / pcplus4_i
//               instr_o, pc_o, pcplus4_o, valid_o - decode-stage outputs
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q,   instr_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q,   valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // hold everything
    end else if (load_i) begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end else begin
      // fetch had nothing to hand over: insert a bubble
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= BUBBLE_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage of the 5-stage RV32I core plus the IF/ID register.
//               Keeps PCF, issues fetches over a req/gnt/rvalid handshake with
//               at most one request outstanding, buffers one response while
//               fetch is stalled and discards responses made stale by an
//               E-stage redirect.
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               StallF, StallD, FlushD     - hazard unit controls
//               PCSrcE, PCTargetE          - E-stage redirect
//               imem_req/addr/gnt/rvalid/rdata - instruction memory interface
//               PCF                        - current fetch PC
//               InstrD, PCD, PCPlus4D, ValidD - decode-stage outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  import riscv_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  buf_instr_q, buf_instr_d;

  logic [31:0]  pcf_plus4;
  logic         rsp_wait;    // response for PCF arriving this cycle
  logic         avail;       // an instruction for PCF is available
  logic         adv;         // hand the instruction to decode and step PCF
  logic [31:0]  fetch_instr;

  assign pcf_plus4   = pcf_q + 32'd4;
  assign rsp_wait    = (state_q == WAIT) && imem_rvalid;
  assign avail       = buf_valid_q | rsp_wait;
  assign adv         = avail & ~StallF & ~PCSrcE;
  assign fetch_instr = buf_valid_q ? buf_instr_q : imem_rdata;

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A request accepted in the same cycle as a redirect is for the old
        // PCF, so its response must be thrown away.
        if (imem_req && imem_gnt) begin
          state_d = PCSrcE ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          state_d = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          // adv here is simply !StallF; a stalled response goes to the buffer
          state_d = (adv && imem_gnt) ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // In WAIT the only request is the back-to-back one for the next PC.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pcf_q;
    if (!reset) begin
      case (state_q)
        IDLE: imem_req = ~buf_valid_q;
        WAIT: begin
          imem_req  = imem_rvalid & adv;
          imem_addr = pcf_plus4;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------- PC and fetch buffer
  always_comb begin
    pcf_d       = pcf_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    if (PCSrcE) begin
      pcf_d       = PCTargetE;
      buf_valid_d = 1'b0;
    end else if (adv) begin
      pcf_d       = pcf_plus4;
      buf_valid_d = 1'b0;
    end else if (rsp_wait && StallF) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q       <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      pcf_q       <= pcf_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign PCF = pcf_q;

  // ---------------------------------------------------------------- IF/ID register
  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (FlushD),
    .stall_i   (StallD),
    .load_i    (adv),
    .instr_i   (fetch_instr),
    .pc_i      (pcf_q),
    .pcplus4_i (pcf_plus4),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pcplus4_o (PCPlus4D),
    .valid_o   (ValidD)
  );

`ifndef SYNTHESIS
  // Decode may only stall when fetch stalls too.
  a_stall_order : assert property (@(posedge clk) disable iff (reset) !(StallD && !StallF));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. Memory
//               handshake signals are driven by hand, cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic valid);
    chk({tag, ".InstrD"},   InstrD,   instr);
    chk({tag, ".PCD"},      PCD,      pc);
    chk({tag, ".PCPlus4D"}, PCPlus4D, pc4);
    chk({tag, ".ValidD"},   {31'd0, ValidD}, {31'd0, valid});
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".InstrD"}, InstrD, C_NOP);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, 32'd0);
  endtask

  // inputs change 1 time unit after the rising edge; checks follow 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h0010_0113;
    prog[1] = 32'h0020_8193;
    prog[2] = 32'h0031_8213;

    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) tick();

    // reset state
    settle();
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.PCF", PCF, 32'h0);
    chk_d("rst", C_NOP, 32'h0, 32'h0, 1'b0);

    // grant withheld for 3 cycles: request held at 0x0, bubbles in D
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_req("nognt", 1'b1, 32'h0);
      tick();
      chk_bubble("nognt");
    end

    // first fetch, 1-cycle latency
    imem_gnt = 1'b1;
    settle();
    chk_req("first.c0", 1'b1, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    settle();
    chk_req("first.c1", 1'b1, 32'h4);
    tick();
    chk_d("first.D", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

    // straight-line stream, one instruction per cycle
    for (int i = 0; i < 3; i++) begin
      imem_rdata = prog[i];
      settle();
      chk_req("line", 1'b1, 32'h8 + 32'(4 * i));
      tick();
      chk_d("line.D", prog[i], 32'h4 + 32'(4 * i), 32'h8 + 32'(4 * i), 1'b1);
    end

    // stalled response is buffered, D held, no new request
    StallF = 1'b1; StallD = 1'b1; imem_rdata = 32'h00A0_0113;
    settle();
    chk_req("stall.c0", 1'b0, 32'h0);
    tick();
    chk_d("stall.c0.D", prog[2], 32'hC, 32'h10, 1'b1);
    chk("stall.c0.PCF", PCF, 32'h10);
    imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    settle();
    chk_req("stall.c1", 1'b0, 32'h0);
    tick();
    chk_d("stall.c1.D", prog[2], 32'hC, 32'h10, 1'b1);
    StallF = 1'b0; StallD = 1'b0;
    settle();
    chk_req("release", 1'b0, 32'h0);
    tick();
    chk_d("release.D", 32'h00A0_0113, 32'h10, 32'h14, 1'b1);
    chk("release.PCF", PCF, 32'h14);
    settle();
    chk_req("after_buf", 1'b1, 32'h14);
    tick();
    chk_bubble("after_buf");

    // redirect while the 0x14 request is still outstanding
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
    settle();
    chk_req("redir.c0", 1'b0, 32'h0);
    tick();
    chk("redir.PCF", PCF, 32'h100);
    chk_bubble("redir.c0");
    PCSrcE = 1'b0; FlushD = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk_req("redir.stale", 1'b0, 32'h0);
    tick();
    chk_bubble("redir.stale");
    imem_rvalid = 1'b0;
    settle();
    chk_req("redir.refetch", 1'b1, 32'h100);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193; imem_gnt = 1'b0;
    settle();
    chk_req("redir.next", 1'b1, 32'h104);
    tick();
    chk_d("redir.D", 32'h0030_0193, 32'h100, 32'h104, 1'b1);

    // reset with a request outstanding, late rvalid around reset
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_req("prerst", 1'b1, 32'h104);
    tick();
    reset = 1'b1;
    settle();
    chk("midrst.req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("midrst.req2", {31'd0, imem_req}, 32'd0);
    tick();
    chk("midrst.PCF", PCF, 32'h0);
    chk_d("midrst", C_NOP, 32'h0, 32'h0, 1'b0);
    reset = 1'b0; imem_gnt = 1'b0;
    settle();
    chk_req("postrst", 1'b1, 32'h0);
    tick();
    chk_bubble("postrst");
    chk("postrst.PCF", PCF, 32'h0);

    // PC wrap-around at the top of the address space
    imem_rvalid = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    settle();
    chk_req("wrap.c0", 1'b1, 32'h0);
    tick();
    chk("wrap.PCF", PCF, 32'hFFFF_FFFC);
    PCSrcE = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_req("wrap.c1", 1'b1, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
    settle();
    chk_req("wrap.c2", 1'b1, 32'h0);
    tick();
    chk_d("wrap.D", 32'h0040_0213, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk("wrap.PCF2", PCF, 32'h0);

    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
